// File: rtl/elevator_display_pkg.sv
// Shared segment patterns and character codes for the elevator display scanner.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment (common anode).
package elevator_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_UP    = 7'b1111110;
  localparam logic [6:0] SEG_DOWN  = 7'b1110111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Character codes: the decimal digits occupy codes 0..9 so a floor
  // number can be cast straight into a code.
  typedef enum logic [3:0] {
    CH_0     = 4'd0,
    CH_1     = 4'd1,
    CH_2     = 4'd2,
    CH_3     = 4'd3,
    CH_4     = 4'd4,
    CH_5     = 4'd5,
    CH_6     = 4'd6,
    CH_7     = 4'd7,
    CH_8     = 4'd8,
    CH_9     = 4'd9,
    CH_H     = 4'd10,
    CH_E     = 4'd11,
    CH_DASH  = 4'd12,
    CH_UP    = 4'd13,
    CH_DOWN  = 4'd14,
    CH_BLANK = 4'd15
  } char_code_t;

endpackage

// File: rtl/elevator_display_scan_seg7_char_decode.sv
// Combinational character-code to active-low seven-segment pattern decoder.
module seg7_char_decode
  import elevator_display_pkg::*;
(
  input  char_code_t  code,
  output logic [6:0]  seg
);

  // Map each character code to its segment pattern; unknown codes blank.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      CH_H:     seg = SEG_H;
      CH_E:     seg = SEG_E;
      CH_DASH:  seg = SEG_DASH;
      CH_UP:    seg = SEG_UP;
      CH_DOWN:  seg = SEG_DOWN;
      CH_BLANK: seg = SEG_BLANK;
      default: begin
        if (code <= CH_9) begin
          seg = SEG_DIGIT[code];
        end else begin
          seg = SEG_BLANK;
        end
      end
    endcase
  end

endmodule

// File: rtl/elevator_display_scan.sv
// Time-multiplexed seven-segment scanner for the elevator display board.
// Digit 0 shows the floor ('E' if out of range, blinking 'H' while held),
// digit 1 the travel direction, remaining digits are blank but still scanned.
// Inputs are captured once per scan frame so no digit tears mid-frame.
module elevator_display_scan
  import elevator_display_pkg::*;
#(
  parameter int NUM_FLOORS   = 5,
  parameter int FLOOR_W      = 4,
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLOOR_W-1:0]    floor,
  input  logic                  hold,
  input  logic                  dir_up,
  input  logic                  dir_down,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam int DI_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BC_W = $clog2(BLINK_FRAMES + 1);

  logic [RC_W-1:0]    refresh_cnt_r;
  logic [DI_W-1:0]    digit_idx_r;
  logic [BC_W-1:0]    blink_cnt_r;
  logic               blink_off_r;
  logic [FLOOR_W-1:0] snap_floor_r;
  logic               snap_hold_r;
  logic               snap_up_r;
  logic               snap_down_r;

  logic               slot_end_s;
  logic               frame_end_s;
  char_code_t         char_s;
  logic [6:0]         glyph_s;

  // Slot and frame boundary detection from the scan counters.
  always_comb begin
    slot_end_s  = (refresh_cnt_r == RC_W'(REFRESH_DIV - 1));
    frame_end_s = slot_end_s && (digit_idx_r == DI_W'(NUM_DIGITS - 1));
  end

  // Refresh divider and digit index: one digit slot every REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt_r <= RC_W'(0);
      digit_idx_r   <= DI_W'(0);
    end else if (slot_end_s) begin
      refresh_cnt_r <= RC_W'(0);
      if (digit_idx_r == DI_W'(NUM_DIGITS - 1)) begin
        digit_idx_r <= DI_W'(0);
      end else begin
        digit_idx_r <= digit_idx_r + DI_W'(1);
      end
    end else begin
      refresh_cnt_r <= refresh_cnt_r + RC_W'(1);
    end
  end

  // Input snapshot, taken only on the last cycle of a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_floor_r <= FLOOR_W'(0);
      snap_hold_r  <= 1'b0;
      snap_up_r    <= 1'b0;
      snap_down_r  <= 1'b0;
    end else if (frame_end_s) begin
      snap_floor_r <= floor;
      snap_hold_r  <= hold;
      snap_up_r    <= dir_up;
      snap_down_r  <= dir_down;
    end else begin
      snap_floor_r <= snap_floor_r;
      snap_hold_r  <= snap_hold_r;
      snap_up_r    <= snap_up_r;
      snap_down_r  <= snap_down_r;
    end
  end

  // Blink phase of the hold 'H', advanced once per frame. The boundary that
  // first captures hold only arms the counter, so every hold episode opens
  // with a full BLINK_FRAMES frames of 'H' before the first blank phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r <= BC_W'(0);
      blink_off_r <= 1'b0;
    end else if (frame_end_s) begin
      if (!hold || !snap_hold_r) begin
        blink_cnt_r <= BC_W'(0);
        blink_off_r <= 1'b0;
      end else if (blink_cnt_r == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_r <= BC_W'(0);
        blink_off_r <= ~blink_off_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BC_W'(1);
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
      blink_off_r <= blink_off_r;
    end
  end

  // Character selection for the digit currently being scanned.
  always_comb begin
    char_s = CH_BLANK;
    if (digit_idx_r == DI_W'(0)) begin
      if (snap_hold_r) begin
        if (blink_off_r) begin
          char_s = CH_BLANK;
        end else begin
          char_s = CH_H;
        end
      end else if (snap_floor_r >= FLOOR_W'(NUM_FLOORS)) begin
        char_s = CH_E;
      end else begin
        char_s = char_code_t'(4'(snap_floor_r));
      end
    end else if (digit_idx_r == DI_W'(1)) begin
      case ({snap_up_r, snap_down_r})
        2'b10:   char_s = CH_UP;
        2'b01:   char_s = CH_DOWN;
        2'b11:   char_s = CH_E;
        default: char_s = CH_DASH;
      endcase
    end else begin
      char_s = CH_BLANK;
    end
  end

  seg7_char_decode u_decode (
    .code (char_s),
    .seg  (glyph_s)
  );

  // Registered display outputs and the frame pulse, one cycle behind the scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg        <= SEG_BLANK;
      an         <= {NUM_DIGITS{1'b1}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= glyph_s;
      an         <= ~(NUM_DIGITS'(1) << digit_idx_r);
      frame_tick <= frame_end_s;
    end
  end

endmodule

// File: tb/tb_elevator_display_scan.sv
// Self-checking bench for elevator_display_scan with a frame-level model.
module tb_elevator_display_scan;

  localparam int RD    = 4;
  localparam int ND    = 4;
  localparam int BF    = 2;
  localparam int NF    = 5;
  localparam int FRAME = RD * ND;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] floor = 4'd0;
  logic       hold = 1'b0;
  logic       dir_up = 1'b0;
  logic       dir_down = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  elevator_display_scan #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (4),
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .floor      (floor),
    .hold       (hold),
    .dir_up     (dir_up),
    .dir_down   (dir_down),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  // Model: cycle count since reset, frame snapshot, and how many frame
  // boundaries hold has been continuously seen after the one that captured it.
  logic [6:0] glyph [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int         m_c;
  logic [3:0] m_floor;
  logic       m_hold, m_up, m_down;
  int         m_run;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_ft;

  function automatic logic [6:0] model_seg(int d);
    if (d == 0) begin
      if (m_hold) return (((m_run / BF) % 2) == 1) ? 7'b1111111 : 7'b0001001;
      if (m_floor >= NF) return 7'b0000110;
      return glyph[m_floor];
    end
    if (d == 1) begin
      if (m_up && m_down) return 7'b0000110;
      if (m_up) return 7'b1111110;
      if (m_down) return 7'b1110111;
      return 7'b0111111;
    end
    return 7'b1111111;
  endfunction

  // Model update alongside the DUT.
  always @(posedge clk) begin
    if (reset) begin
      m_c     <= 0;
      m_floor <= 4'd0;
      m_hold  <= 1'b0;
      m_up    <= 1'b0;
      m_down  <= 1'b0;
      m_run   <= 0;
      e_seg   <= 7'b1111111;
      e_an    <= 4'b1111;
      e_ft    <= 1'b0;
    end else begin
      e_an  <= ~(4'b0001 << ((m_c / RD) % ND));
      e_seg <= model_seg((m_c / RD) % ND);
      e_ft  <= ((m_c % FRAME) == FRAME - 1);
      if ((m_c % FRAME) == FRAME - 1) begin
        m_floor <= floor;
        m_hold  <= hold;
        m_up    <= dir_up;
        m_down  <= dir_down;
        m_run   <= (!hold) ? 0 : (m_hold ? m_run + 1 : 0);
      end
      m_c <= m_c + 1;
    end
  end

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_seg", 32'(seg), 32'(e_seg));
      cmp("model_an", 32'(an), 32'(e_an));
      cmp("model_tick", 32'(frame_tick), 32'(e_ft));
    end
  end

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    cmp("tick_seen", 32'(frame_tick), 32'd1);
  endtask

  task automatic check_slot(string nm, logic [3:0] want_an, logic [6:0] want_seg);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== want_an && n < 40);
    cmp({nm, "_an"}, 32'(an), 32'(want_an));
    cmp(nm, 32'(seg), 32'(want_seg));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    cmp("reset_an", 32'(an), 32'b1111);
    cmp("reset_seg", 32'(seg), 32'b1111111);
    reset = 1'b0;
    floor = 4'd3;

    // Floor 3, no direction.
    wait_tick();
    check_slot("f3_d0", 4'b1110, 7'b0110000);
    check_slot("f3_d1", 4'b1101, 7'b0111111);
    check_slot("f3_d2", 4'b1011, 7'b1111111);
    check_slot("f3_d3", 4'b0111, 7'b1111111);

    // Floor 2 then 4 mid-frame.
    floor = 4'd2;
    wait_tick();
    check_slot("f2_d0", 4'b1110, 7'b0100100);
    floor = 4'd4;
    check_slot("f2_hold_d1", 4'b1101, 7'b0111111);
    wait_tick();
    check_slot("f4_d0", 4'b1110, 7'b0011001);

    // Out-of-range floor and conflicting direction.
    floor = 4'd7;
    dir_up = 1'b1;
    dir_down = 1'b1;
    wait_tick();
    check_slot("oor_d0", 4'b1110, 7'b0000110);
    check_slot("both_d1", 4'b1101, 7'b0000110);

    // Hold blink sequence.
    floor = 4'd1;
    dir_up = 1'b0;
    dir_down = 1'b0;
    hold = 1'b1;
    wait_tick();
    check_slot("hold_f1", 4'b1110, 7'b0001001);
    wait_tick();
    check_slot("hold_f2", 4'b1110, 7'b0001001);
    wait_tick();
    check_slot("hold_f3", 4'b1110, 7'b1111111);
    wait_tick();
    check_slot("hold_f4", 4'b1110, 7'b1111111);
    wait_tick();
    check_slot("hold_f5", 4'b1110, 7'b0001001);
    hold = 1'b0;
    wait_tick();
    check_slot("unhold", 4'b1110, 7'b1111001);
    hold = 1'b1;
    wait_tick();
    check_slot("rehold", 4'b1110, 7'b0001001);

    // Down direction and frame period.
    hold = 1'b0;
    floor = 4'd0;
    dir_down = 1'b1;
    wait_tick();
    check_slot("down_d1", 4'b1101, 7'b1110111);
    wait_tick();
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!frame_tick && n < 40);
      cmp("tick_period", 32'(n), 32'd16);
    end

    // Reset mid-frame.
    floor = 4'd6;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== 4'b1011 && n < 40);
    cmp("pre_reset_an", 32'(an), 32'b1011);
    reset = 1'b1;
    @(negedge clk);
    cmp("mid_reset_an", 32'(an), 32'b1111);
    cmp("mid_reset_seg", 32'(seg), 32'b1111111);
    reset = 1'b0;
    @(negedge clk);
    cmp("post_reset_an", 32'(an), 32'b1110);
    cmp("post_reset_seg", 32'(seg), 32'b1000000);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
